// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding and op codes.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    ZERO  = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_sequencer.sv
// Sequences one mult/div operation: init pulse, bounded wait for the unit's stop
// flag, then Hi/Lo load, divide-by-zero or timeout report back to the control unit.
module muldiv_sequencer #(
  parameter int unsigned MULT_MAX_CYCLES = 40,
  parameter int unsigned DIV_MAX_CYCLES  = 40,
  parameter int unsigned CNT_W           = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  input  logic mult_stop,
  input  logic div_stop,
  input  logic div_zero,
  output logic mult_init,
  output logic div_init,
  output logic hilo_sel,
  output logic high_load,
  output logic low_load,
  output logic busy,
  output logic done,
  output logic div_by_zero,
  output logic timeout
);
  import muldiv_pkg::*;

  localparam logic [CNT_W-1:0] MULT_MAX = CNT_W'(MULT_MAX_CYCLES);
  localparam logic [CNT_W-1:0] DIV_MAX  = CNT_W'(DIV_MAX_CYCLES);

  state_t           state, state_nxt;
  logic             op_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sel_max;
  logic             sel_stop;

  // Only the selected unit's flags matter; the other unit may be left idle or noisy.
  assign sel_max  = (op_q == OP_DIV) ? DIV_MAX  : MULT_MAX;
  assign sel_stop = (op_q == OP_DIV) ? div_stop : mult_stop;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q <= OP_MULT;
      cnt  <= '0;
    end else if (state == IDLE && start) begin
      op_q <= op;
      cnt  <= '0;
    end else if (state == WAIT && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = INIT;
      INIT:  state_nxt = WAIT;
      WAIT: begin
        // Divide-by-zero outranks a simultaneous stop; a stop outranks the timeout.
        if (op_q == OP_DIV && div_zero) state_nxt = ZERO;
        else if (sel_stop)              state_nxt = WRITE;
        else if (cnt == sel_max)        state_nxt = FAULT;
      end
      WRITE, ZERO, FAULT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mult_init   = 1'b0;
    div_init    = 1'b0;
    high_load   = 1'b0;
    low_load    = 1'b0;
    done        = 1'b0;
    div_by_zero = 1'b0;
    timeout     = 1'b0;
    busy        = (state != IDLE);
    hilo_sel    = op_q;
    case (state)
      INIT: begin
        mult_init = (op_q == OP_MULT);
        div_init  = (op_q == OP_DIV);
      end
      WRITE: begin
        high_load = 1'b1;
        low_load  = 1'b1;
        done      = 1'b1;
      end
      ZERO:    div_by_zero = 1'b1;
      FAULT:   timeout     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level model keyed on cycle offsets.
module tb_muldiv_sequencer;

  localparam int MULT_MAX = 4;
  localparam int DIV_MAX  = 6;

  logic clk = 1'b0;
  logic reset, start, op, mult_stop, div_stop, div_zero;
  logic mult_init, div_init, hilo_sel, high_load, low_load;
  logic busy, done, div_by_zero, timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: start cycle of the live operation, cycle of its terminal pulse and its kind.
  int   m_start = -1;
  int   m_end   = -1;
  int   m_kind  = 0;
  logic m_op    = 1'b0;
  bit   m_known = 1'b0;

  always #5 clk = ~clk;

  muldiv_sequencer #(
    .MULT_MAX_CYCLES(MULT_MAX),
    .DIV_MAX_CYCLES (DIV_MAX),
    .CNT_W          (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .mult_stop  (mult_stop),
    .div_stop   (div_stop),
    .div_zero   (div_zero),
    .mult_init  (mult_init),
    .div_init   (div_init),
    .hilo_sel   (hilo_sel),
    .high_load  (high_load),
    .low_load   (low_load),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .timeout    (timeout)
  );

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", tag, cyc, obs, exp);
    end
  endtask

  // One bench cycle: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic st, input logic o, input logic ms, input logic ds,
                      input logic dz, input logic rs);
    logic e_mi, e_di, e_hl, e_ll, e_busy, e_done, e_dbz, e_to;
    logic stp;
    int   k, mx;
    @(posedge clk);
    #1;
    start = st; op = o; mult_stop = ms; div_stop = ds; div_zero = dz; reset = rs;
    @(negedge clk);
    if (m_known) begin
      {e_mi, e_di, e_hl, e_ll, e_busy, e_done, e_dbz, e_to} = '0;
      if (m_end == cyc) begin
        e_busy = 1'b1;
        case (m_kind)
          0:       begin e_hl = 1'b1; e_ll = 1'b1; e_done = 1'b1; end
          1:       e_dbz = 1'b1;
          default: e_to  = 1'b1;
        endcase
      end else if (m_start >= 0) begin
        e_busy = 1'b1;
        if (cyc == m_start + 1) begin
          e_mi = !m_op;
          e_di = m_op;
        end
      end
      check_eq("mult_init",   mult_init,   e_mi);
      check_eq("div_init",    div_init,    e_di);
      check_eq("hilo_sel",    hilo_sel,    m_op);
      check_eq("high_load",   high_load,   e_hl);
      check_eq("low_load",    low_load,    e_ll);
      check_eq("busy",        busy,        e_busy);
      check_eq("done",        done,        e_done);
      check_eq("div_by_zero", div_by_zero, e_dbz);
      check_eq("timeout",     timeout,     e_to);
    end
    if (!rs) begin
      m_known = 1'b1;
      m_start = -1;
      m_end   = -1;
      m_op    = 1'b0;
    end else if (m_known) begin
      if (m_end == cyc) begin
        m_start = -1;
        m_end   = -1;
      end else if (m_start < 0) begin
        if (st) begin
          m_start = cyc;
          m_op    = o;
        end
      end else if (cyc >= m_start + 2 && m_end < 0) begin
        // k-th WAIT cycle; k-1 full wait cycles have elapsed before it.
        k   = cyc - m_start - 1;
        mx  = m_op ? DIV_MAX : MULT_MAX;
        stp = m_op ? ds : ms;
        if (m_op && dz)     begin m_end = cyc + 1; m_kind = 1; end
        else if (stp)       begin m_end = cyc + 1; m_kind = 0; end
        else if (k - 1 == mx) begin m_end = cyc + 1; m_kind = 2; end
      end
    end
    cyc++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 1'b0;
    mult_stop = 1'b0; div_stop = 1'b0; div_zero = 1'b0;

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle_n(2);

    // MULT normal completion: stop in relative cycle 5.
    step(1, 0, 0, 0, 0, 1);
    idle_n(4);
    step(0, 0, 1, 0, 0, 1);
    idle_n(3);

    // DIV by zero with simultaneous stop in relative cycle 4.
    step(1, 1, 0, 0, 0, 1);
    idle_n(3);
    step(0, 0, 0, 1, 1, 1);
    idle_n(3);

    // MULT timeout, stop never asserted; noise on div flags must be ignored.
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, i[0], i[1], 1);

    // DIV timeout.
    step(1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, i[0], 0, 0, 1);

    // Start with op=1 while a MULT is busy, in cycle 3 and in the WRITE cycle 6.
    step(1, 0, 0, 0, 0, 1);
    idle_n(2);
    step(1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    idle_n(3);

    // Reset in relative cycle 3 of a DIV, then a stale stop in cycle 5.
    step(1, 1, 0, 0, 0, 1);
    idle_n(2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    idle_n(3);

    // Back-to-back: start accepted the cycle after a terminal pulse.
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    idle_n(3);

    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(3) == 0, 1'($urandom_range(1)),
           $urandom_range(9) == 0, $urandom_range(9) == 0,
           $urandom_range(19) == 0, $urandom_range(199) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
